flg_addr_gen: RTL and testbench
===============================

// Module: flg_addr_gen
// PURPOSE
// Downstream of the flag-offset stage. Consumes per-match (Offset_Act, Offset_Wei, ValFlag) results
// for one DATA_WIDTH-channel flag word and turns them into absolute read addresses into the
// compressed activation and weight buffers. Issues one read pair per matched channel to the MAC
// fetch stage, counts the matches and returns the buffer bases for the next flag word.
// PARAMETERS
// DATA_WIDTH  32  channels per flag word
// ADDR_WIDTH  10  compressed-buffer address width; addresses wrap mod 2^ADDR_WIDTH
// OFF_W       `C_LOG_2(DATA_WIDTH)  offset width
// PORTS
// clk            in   1           clock
// rst_n          in   1           async active-low reset
// I_Sta          in   1           pulse: start a new flag word, latch bases
// I_Base_Act     in   ADDR_WIDTH  act buffer address of the word's first nonzero
// I_Base_Wei     in   ADDR_WIDTH  wei buffer address of the word's first nonzero
// I_Off_Val      in   1           offset triple valid
// O_Off_Rdy      out  1           offset triple accepted (drives upstream I_ActWei_Val)
// I_ValFlag      in   1           1 = a match exists at this offset; 0 = word exhausted
// I_Offset_Act   in   OFF_W       act-only nonzeros skipped before the match / to word end
// I_Offset_Wei   in   OFF_W       wei-only nonzeros skipped before the match / to word end
// O_Rd_Val       out  1           read pair valid
// I_Rd_Rdy       in   1           MAC fetch accepts the read pair
// O_RdAddr_Act   out  ADDR_WIDTH  act read address
// O_RdAddr_Wei   out  ADDR_WIDTH  wei read address
// O_Done         out  1           1-cycle pulse: word finished, all reads accepted
// O_PairCnt      out  OFF_W+1     matches issued for the word (valid with O_Done, held)
// O_NextBase_Act out  ADDR_WIDTH  act base for the next word (valid with O_Done, held)
// O_NextBase_Wei out  ADDR_WIDTH  wei base for the next word (valid with O_Done, held)
// BEHAVIOUR
// - Reset: state IDLE; every output 0; internal pointers and counter 0.
// - FSM IDLE->RUN on I_Sta: ptr_act<=I_Base_Act, ptr_wei<=I_Base_Wei, cnt<=0, O_Rd_Val<=0.
// - O_Off_Rdy = (state==RUN) & (~O_Rd_Val | I_Rd_Rdy); 0 in every other state. Transfer = I_Off_Val & O_Off_Rdy.
// - RUN, transfer with I_ValFlag=1: next cycle O_Rd_Val=1, O_RdAddr_Act=ptr_act+I_Offset_Act,
//   O_RdAddr_Wei=ptr_wei+I_Offset_Wei; ptr_x<=ptr_x+I_Offset_x+1; cnt<=cnt+1. Latency 1 cycle.
// - RUN, transfer with I_ValFlag=0: no read issued; ptr_x<=ptr_x+I_Offset_x; go DRAIN.
// - O_Rd_Val holds with stable addresses until I_Rd_Rdy; cleared on acceptance with no new transfer.
//   Back-to-back: accept + new transfer in same cycle keeps O_Rd_Val=1 with new addresses (full rate).
// - DRAIN: wait until O_Rd_Val==0 or (O_Rd_Val & I_Rd_Rdy); then DONE.
// - DONE (1 cycle): O_Done=1; O_PairCnt<=cnt, O_NextBase_x<=ptr_x (held until next DONE or reset); ->IDLE.
// - All address adds are ADDR_WIDTH wide, carry discarded (wrap 2^ADDR_WIDTH-1 -> 0).
// - cnt max = DATA_WIDTH (all channels match); OFF_W+1 bits never saturates.
// - I_Sta in RUN/DRAIN/DONE: abort; pending O_Rd_Val dropped, no O_Done, reload bases, ->RUN.
// - I_Sta and I_Off_Val same cycle: I_Sta wins, offsets not accepted (O_Off_Rdy=0 that cycle).
// - I_Off_Val outside RUN is ignored; I_Rd_Rdy without O_Rd_Val is ignored.
// - Async reset mid-word: immediate return to reset values, no O_Done.
// TESTING
// 1 Bases 100/200; triples (V1,2,0),(V1,0,3),(V0,1,1), I_Rd_Rdy=1 -> reads (102,200),(103,204);
//   O_Done, PairCnt=2, NextBase 105/206.
// 2 Same stimulus, I_Rd_Rdy low 3 cycles on first read -> O_Off_Rdy=0, addresses held, same final result.
// 3 Base_Act=1022 (ADDR_WIDTH=10), triple (V1,3,0) -> RdAddr_Act=1, ptr_act=2 (wrap).
// 4 32 triples (V1,0,0) then (V0,0,0), base 0/0 -> 32 reads addr k/k, PairCnt=32, NextBase 32/32.
// 5 I_Sta mid-RUN with pending read -> O_Rd_Val drops, no O_Done, new bases used for next read.
// 6 rst_n low while O_Rd_Val=1 -> all outputs 0 immediately; first triple (V0,0,0) -> O_Done, PairCnt=0.

Source files
------------

// File: rtl/flg_addr_gen_if.sv
// Flag address generator bus: offset-triple input, read-pair output, word result.
// slave = generator side, master = driver side (flag-offset stage, MAC fetch).
`timescale 1ns/1ps
interface flg_addr_gen_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int OFF_W      = $clog2(DATA_WIDTH)
);
  logic                  I_Sta;
  logic [ADDR_WIDTH-1:0] I_Base_Act;
  logic [ADDR_WIDTH-1:0] I_Base_Wei;
  logic                  I_Off_Val;
  logic                  O_Off_Rdy;
  logic                  I_ValFlag;
  logic [OFF_W-1:0]      I_Offset_Act;
  logic [OFF_W-1:0]      I_Offset_Wei;
  logic                  O_Rd_Val;
  logic                  I_Rd_Rdy;
  logic [ADDR_WIDTH-1:0] O_RdAddr_Act;
  logic [ADDR_WIDTH-1:0] O_RdAddr_Wei;
  logic                  O_Done;
  logic [OFF_W:0]        O_PairCnt;
  logic [ADDR_WIDTH-1:0] O_NextBase_Act;
  logic [ADDR_WIDTH-1:0] O_NextBase_Wei;

  modport slave (
    input  I_Sta, I_Base_Act, I_Base_Wei,
    input  I_Off_Val, I_ValFlag,
    input  I_Offset_Act, I_Offset_Wei,
    input  I_Rd_Rdy,
    output O_Off_Rdy, O_Rd_Val,
    output O_RdAddr_Act, O_RdAddr_Wei,
    output O_Done, O_PairCnt,
    output O_NextBase_Act, O_NextBase_Wei
  );

  modport master (
    output I_Sta, I_Base_Act, I_Base_Wei,
    output I_Off_Val, I_ValFlag,
    output I_Offset_Act, I_Offset_Wei,
    output I_Rd_Rdy,
    input  O_Off_Rdy, O_Rd_Val,
    input  O_RdAddr_Act, O_RdAddr_Wei,
    input  O_Done, O_PairCnt,
    input  O_NextBase_Act, O_NextBase_Wei
  );
endinterface

// File: rtl/flg_addr_gen.sv
// Turns per-match (offset_act, offset_wei, valflag) triples into absolute
// compressed-buffer read pairs; ports: clk, rst_n, bus (flg_addr_gen_if.slave).
`timescale 1ns/1ps
module flg_addr_gen #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int OFF_W      = $clog2(DATA_WIDTH)
) (
  input  logic           clk,
  input  logic           rst_n,
  flg_addr_gen_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_n;

  logic [ADDR_WIDTH-1:0] r_ptr_act;
  logic [ADDR_WIDTH-1:0] r_ptr_wei;
  logic [OFF_W:0]        r_cnt;
  logic                  r_rd_val;
  logic [ADDR_WIDTH-1:0] r_rd_act;
  logic [ADDR_WIDTH-1:0] r_rd_wei;
  logic [OFF_W:0]        r_pair_cnt;
  logic [ADDR_WIDTH-1:0] r_nb_act;
  logic [ADDR_WIDTH-1:0] r_nb_wei;

  logic                  w_off_rdy;
  logic                  w_xfer;
  logic                  w_hit;
  logic                  w_drained;
  logic [ADDR_WIDTH-1:0] w_off_act;
  logic [ADDR_WIDTH-1:0] w_off_wei;
  logic [ADDR_WIDTH-1:0] w_inc;

  // I_Sta takes priority over any offset triple offered alongside it.
  assign w_off_rdy = (r_state == S_RUN) & ~bus.I_Sta
                   & (~r_rd_val | bus.I_Rd_Rdy);
  assign w_xfer    = bus.I_Off_Val & w_off_rdy;
  assign w_hit     = w_xfer & bus.I_ValFlag;
  assign w_drained = ~r_rd_val | bus.I_Rd_Rdy;

  assign w_off_act = ADDR_WIDTH'(bus.I_Offset_Act);
  assign w_off_wei = ADDR_WIDTH'(bus.I_Offset_Wei);
  // A match consumes its own slot too, so the pointer steps one past it.
  assign w_inc     = ADDR_WIDTH'(bus.I_ValFlag);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_n;
  end

  always_comb begin
    w_state_n = r_state;
    if (bus.I_Sta) begin
      w_state_n = S_RUN;
    end else begin
      unique case (r_state)
        S_IDLE:  w_state_n = S_IDLE;
        S_RUN: begin
          if (w_xfer && !bus.I_ValFlag)
            w_state_n = S_DRAIN;
        end
        S_DRAIN: begin
          if (w_drained) w_state_n = S_DONE;
        end
        S_DONE:  w_state_n = S_IDLE;
        default: w_state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr_act  <= '0;
      r_ptr_wei  <= '0;
      r_cnt      <= '0;
      r_rd_val   <= 1'b0;
      r_rd_act   <= '0;
      r_rd_wei   <= '0;
      r_pair_cnt <= '0;
      r_nb_act   <= '0;
      r_nb_wei   <= '0;
    end else if (bus.I_Sta) begin
      r_ptr_act <= bus.I_Base_Act;
      r_ptr_wei <= bus.I_Base_Wei;
      r_cnt     <= '0;
      r_rd_val  <= 1'b0;
    end else begin
      if (w_xfer) begin
        r_ptr_act <= r_ptr_act + w_off_act + w_inc;
        r_ptr_wei <= r_ptr_wei + w_off_wei + w_inc;
      end
      if (w_hit) begin
        r_rd_val <= 1'b1;
        r_rd_act <= r_ptr_act + w_off_act;
        r_rd_wei <= r_ptr_wei + w_off_wei;
        r_cnt    <= r_cnt + (OFF_W+1)'(1);
      end else if (bus.I_Rd_Rdy) begin
        r_rd_val <= 1'b0;
      end
      // Result registers load on entry to DONE so they are valid with O_Done.
      if (r_state == S_DRAIN && w_drained) begin
        r_pair_cnt <= r_cnt;
        r_nb_act   <= r_ptr_act;
        r_nb_wei   <= r_ptr_wei;
      end
    end
  end

  assign bus.O_Off_Rdy      = w_off_rdy;
  assign bus.O_Rd_Val       = r_rd_val;
  assign bus.O_RdAddr_Act   = r_rd_act;
  assign bus.O_RdAddr_Wei   = r_rd_wei;
  assign bus.O_Done         = (r_state == S_DONE) & ~bus.I_Sta;
  assign bus.O_PairCnt      = r_pair_cnt;
  assign bus.O_NextBase_Act = r_nb_act;
  assign bus.O_NextBase_Wei = r_nb_wei;

endmodule

// File: tb/tb_flg_addr_gen.sv
// Scoreboard bench for flg_addr_gen: stimulus pushes expected reads/results,
// a negedge monitor pops and compares whenever the DUT presents them.
`timescale 1ns/1ps
module tb_flg_addr_gen;
  localparam int AW = 10;
  localparam int OW = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  flg_addr_gen_if #(.DATA_WIDTH(32), .ADDR_WIDTH(AW)) bus ();

  flg_addr_gen #(.DATA_WIDTH(32), .ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [19:0] rq[$];
  logic [25:0] dq[$];
  logic [19:0] e_rd;
  logic [25:0] e_dn;
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %h want %h", nm, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.O_Rd_Val && bus.I_Rd_Rdy) begin
        if (rq.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL rd_unexpected got %h want none",
                   {bus.O_RdAddr_Act, bus.O_RdAddr_Wei});
        end else begin
          e_rd = rq.pop_front();
          chk("rd_addr",
              {12'd0, bus.O_RdAddr_Act, bus.O_RdAddr_Wei},
              {12'd0, e_rd});
        end
      end
      if (bus.O_Done) begin
        if (dq.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL done_unexpected got %h want none",
                   bus.O_PairCnt);
        end else begin
          e_dn = dq.pop_front();
          chk("done_result",
              {6'd0, bus.O_PairCnt,
               bus.O_NextBase_Act, bus.O_NextBase_Wei},
              {6'd0, e_dn});
        end
      end
    end
  end

  task automatic start(input logic [AW-1:0] a,
                       input logic [AW-1:0] w);
    bus.I_Sta      = 1'b1;
    bus.I_Base_Act = a;
    bus.I_Base_Wei = w;
    @(posedge clk);
    #1;
    bus.I_Sta = 1'b0;
  endtask

  // Leaves I_Off_Val high so consecutive calls run at full rate.
  task automatic send(input logic v,
                      input logic [OW-1:0] oa,
                      input logic [OW-1:0] ow);
    int n;
    bus.I_Off_Val    = 1'b1;
    bus.I_ValFlag    = v;
    bus.I_Offset_Act = oa;
    bus.I_Offset_Wei = ow;
    n = 0;
    @(negedge clk);
    while (!bus.O_Off_Rdy && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (n >= 50) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_timeout got rdy=0 want rdy=1");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_empty(input string nm);
    int n;
    n = 0;
    while ((rq.size() != 0 || dq.size() != 0) && n < 200) begin
      @(posedge clk);
      n++;
    end
    chk(nm, rq.size() + dq.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    bus.I_Sta        = 1'b0;
    bus.I_Base_Act   = '0;
    bus.I_Base_Wei   = '0;
    bus.I_Off_Val    = 1'b0;
    bus.I_ValFlag    = 1'b0;
    bus.I_Offset_Act = '0;
    bus.I_Offset_Wei = '0;
    bus.I_Rd_Rdy     = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_rd_val", bus.O_Rd_Val, 0);
    chk("rst_off_rdy", bus.O_Off_Rdy, 0);
    chk("rst_done", bus.O_Done, 0);
    chk("rst_result",
        {bus.O_PairCnt, bus.O_NextBase_Act, bus.O_NextBase_Wei}, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Test 1: basic word, reader always ready.
    bus.I_Rd_Rdy = 1'b1;
    rq.push_back({10'd102, 10'd200});
    rq.push_back({10'd103, 10'd204});
    dq.push_back({6'd2, 10'd105, 10'd206});
    start(10'd100, 10'd200);
    send(1'b1, 5'd2, 5'd0);
    send(1'b1, 5'd0, 5'd3);
    send(1'b0, 5'd1, 5'd1);
    bus.I_Off_Val = 1'b0;
    wait_empty("t1_drain");

    // Test 2: reader stalls the first read for 3 cycles.
    bus.I_Rd_Rdy = 1'b0;
    rq.push_back({10'd102, 10'd200});
    rq.push_back({10'd103, 10'd204});
    dq.push_back({6'd2, 10'd105, 10'd206});
    start(10'd100, 10'd200);
    send(1'b1, 5'd2, 5'd0);
    fork
      send(1'b1, 5'd0, 5'd3);
      begin
        repeat (3) begin
          @(negedge clk);
          chk("t2_stall_rdy", bus.O_Off_Rdy, 0);
          chk("t2_hold",
              {bus.O_Rd_Val, bus.O_RdAddr_Act, bus.O_RdAddr_Wei},
              {1'b1, 10'd102, 10'd200});
        end
        @(posedge clk);
        #1;
        bus.I_Rd_Rdy = 1'b1;
      end
    join
    send(1'b0, 5'd1, 5'd1);
    bus.I_Off_Val = 1'b0;
    wait_empty("t2_drain");

    // Test 3: address wrap at 2^ADDR_WIDTH.
    rq.push_back({10'd1, 10'd0});
    dq.push_back({6'd1, 10'd2, 10'd1});
    start(10'd1022, 10'd0);
    send(1'b1, 5'd3, 5'd0);
    send(1'b0, 5'd0, 5'd0);
    bus.I_Off_Val = 1'b0;
    wait_empty("t3_drain");

    // Test 4: every channel matches, full rate.
    start(10'd0, 10'd0);
    for (int k = 0; k < 32; k++) begin
      rq.push_back({k[9:0], k[9:0]});
      send(1'b1, 5'd0, 5'd0);
    end
    dq.push_back({6'd32, 10'd32, 10'd32});
    send(1'b0, 5'd0, 5'd0);
    bus.I_Off_Val = 1'b0;
    wait_empty("t4_drain");

    // Test 5: restart while a read is pending.
    bus.I_Rd_Rdy = 1'b0;
    start(10'd10, 10'd20);
    send(1'b1, 5'd1, 5'd1);
    bus.I_Off_Val = 1'b0;
    @(negedge clk);
    chk("t5_pending",
        {bus.O_Rd_Val, bus.O_RdAddr_Act, bus.O_RdAddr_Wei},
        {1'b1, 10'd11, 10'd21});
    start(10'd500, 10'd600);
    @(negedge clk);
    chk("t5_dropped", bus.O_Rd_Val, 0);
    chk("t5_no_done", bus.O_Done, 0);
    @(posedge clk);
    #1;
    bus.I_Rd_Rdy = 1'b1;
    rq.push_back({10'd500, 10'd600});
    dq.push_back({6'd1, 10'd501, 10'd601});
    send(1'b1, 5'd0, 5'd0);
    send(1'b0, 5'd0, 5'd0);
    bus.I_Off_Val = 1'b0;
    wait_empty("t5_drain");

    // Test 6: async reset with a read outstanding.
    bus.I_Rd_Rdy = 1'b0;
    start(10'd0, 10'd0);
    send(1'b1, 5'd5, 5'd6);
    bus.I_Off_Val = 1'b0;
    @(negedge clk);
    chk("t6_pending",
        {bus.O_Rd_Val, bus.O_RdAddr_Act, bus.O_RdAddr_Wei},
        {1'b1, 10'd5, 10'd6});
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_rd",
        {bus.O_Rd_Val, bus.O_RdAddr_Act, bus.O_RdAddr_Wei}, 0);
    chk("t6_rst_result",
        {bus.O_Done, bus.O_PairCnt,
         bus.O_NextBase_Act, bus.O_NextBase_Wei}, 0);
    chk("t6_rst_rdy", bus.O_Off_Rdy, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.I_Rd_Rdy = 1'b1;
    dq.push_back({6'd0, 10'd7, 10'd9});
    start(10'd7, 10'd9);
    send(1'b0, 5'd0, 5'd0);
    bus.I_Off_Val = 1'b0;
    wait_empty("t6_drain");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
